// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry direction prediction.
// Same-cycle lookup on the fetch port, edge-triggered writeback on the update port.
// Build option: define BTB_HYSTERESIS_EN for 2-bit direction counters per entry.
// Without it, an entry means "taken", and a not-taken hit drops the entry.
module btb_assoc #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SETS   = 16,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned OFFSET = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_pred_addr,
    output logic              o_hit,
    output logic              o_taken,
    output logic [ADDR_W-1:0] o_target,
    input  logic              i_upd_en,
    input  logic [ADDR_W-1:0] i_upd_addr,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_upd_target,
    input  logic              i_flush
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - OFFSET - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic              valid_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
    logic [ADDR_W-1:0] target_q [SETS][WAYS];
    logic [WAY_W-1:0]  vp_q     [SETS];
`ifdef BTB_HYSTERESIS_EN
    logic [1:0]        ctr_q    [SETS][WAYS];
    logic [1:0]        ctr_cur;
    logic [1:0]        ctr_upd;
    logic [1:0]        ctr_post;
`endif

    logic [IDX_W-1:0]  p_idx;
    logic [TAG_W-1:0]  p_tag;
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;

    logic              p_hit;
    logic [WAY_W-1:0]  p_way;
    logic              u_hit;
    logic [WAY_W-1:0]  u_way;
    logic              u_free;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  vp_next;
    logic              fwd;
    logic              post_valid;

    assign p_idx = i_pred_addr[OFFSET +: IDX_W];
    assign p_tag = i_pred_addr[ADDR_W-1 -: TAG_W];
    assign u_idx = i_upd_addr[OFFSET +: IDX_W];
    assign u_tag = i_upd_addr[ADDR_W-1 -: TAG_W];

    // Fetch-side tag match across the ways of the indexed set
    always_comb begin
        p_hit = 1'b0;
        p_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[p_idx][w] && (tag_q[p_idx][w] == p_tag)) begin
                p_hit = 1'b1;
                p_way = WAY_W'(w);
            end
        end
    end

    // Update-side tag match plus victim choice: lowest invalid way, else the set's pointer
    always_comb begin
        u_hit  = 1'b0;
        u_way  = '0;
        u_free = 1'b0;
        victim = vp_q[u_idx];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!u_free && !valid_q[u_idx][w]) begin
                u_free = 1'b1;
                victim = WAY_W'(w);
            end
        end
        vp_next = (victim == WAY_W'(WAYS - 1)) ? '0 : victim + WAY_W'(1);
    end

`ifdef BTB_HYSTERESIS_EN
    // Saturating counter step for the matching entry and the counter value seen after the update
    always_comb begin
        ctr_cur = ctr_q[u_idx][u_way];
        if (i_upd_taken) begin
            ctr_upd = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
        end else begin
            ctr_upd = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
        end
        ctr_post = u_hit ? ctr_upd : 2'b10;
    end
`endif

    assign fwd = i_upd_en && !i_flush && (i_pred_addr == i_upd_addr);
`ifdef BTB_HYSTERESIS_EN
    assign post_valid = u_hit || i_upd_taken;
`else
    assign post_valid = i_upd_taken;
`endif

    // Lookup result, overridden by the in-flight update when it targets the same PC
    always_comb begin
        o_hit    = p_hit;
        o_target = p_hit ? target_q[p_idx][p_way] : '0;
`ifdef BTB_HYSTERESIS_EN
        o_taken  = p_hit && ctr_q[p_idx][p_way][1];
`else
        o_taken  = p_hit;
`endif
        if (fwd) begin
            o_hit    = post_valid;
            o_target = post_valid ? i_upd_target : '0;
`ifdef BTB_HYSTERESIS_EN
            o_taken  = post_valid && ctr_post[1];
`else
            o_taken  = post_valid;
`endif
        end
    end

    // Table state: reset, flush (wins over update), then hit refresh or miss allocation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                vp_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
`ifdef BTB_HYSTERESIS_EN
                    ctr_q[s][w]    <= '0;
`endif
                end
            end
        end else if (i_flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                vp_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (i_upd_en) begin
            if (u_hit) begin
`ifdef BTB_HYSTERESIS_EN
                target_q[u_idx][u_way] <= i_upd_target;
                ctr_q[u_idx][u_way]    <= ctr_upd;
`else
                if (i_upd_taken) begin
                    target_q[u_idx][u_way] <= i_upd_target;
                end else begin
                    valid_q[u_idx][u_way]  <= 1'b0;
                end
`endif
            end else if (i_upd_taken) begin
                valid_q[u_idx][victim]  <= 1'b1;
                tag_q[u_idx][victim]    <= u_tag;
                target_q[u_idx][victim] <= i_upd_target;
`ifdef BTB_HYSTERESIS_EN
                ctr_q[u_idx][victim]    <= 2'b10;
`endif
                vp_q[u_idx]             <= vp_next;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed table-driven bench for btb_assoc (SETS=16, WAYS=2, OFFSET=2).
// Each vector is one cycle: inputs applied after the edge, outputs checked at the
// falling edge (so forwarding is visible), state committed at the next rising edge.
module tb_btb_assoc;

    logic        clk;
    logic        rst_n;
    logic [31:0] pred_addr;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        upd_en;
    logic [31:0] upd_addr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        upd_en;
        logic [31:0] upd_addr;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        flush;
        logic [31:0] pred_addr;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_target;
        string       name;
    } vec_t;

    vec_t vecs[$];

    btb_assoc #(.ADDR_W(32), .SETS(16), .WAYS(2), .OFFSET(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pred_addr  (pred_addr),
        .o_hit        (hit),
        .o_taken      (taken),
        .o_target     (target),
        .i_upd_en     (upd_en),
        .i_upd_addr   (upd_addr),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target),
        .i_flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string nm, input logic ue, input logic [31:0] ua, input logic ut,
                       input logic [31:0] utg, input logic fl, input logic [31:0] pa,
                       input logic eh, input logic et, input logic [31:0] etg);
        vec_t v;
        v.name = nm; v.upd_en = ue; v.upd_addr = ua; v.upd_taken = ut; v.upd_target = utg;
        v.flush = fl; v.pred_addr = pa; v.e_hit = eh; v.e_taken = et; v.e_target = etg;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic eh, input logic et, input logic [31:0] etg);
        chk({nm, ".hit"},    32'(hit),   32'(eh));
        chk({nm, ".taken"},  32'(taken), 32'(et));
        chk({nm, ".target"}, target,     etg);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; pred_addr = '0; upd_en = 1'b0; upd_addr = '0;
        upd_taken = 1'b0; upd_target = '0; flush = 1'b0;

        //   name        ue  upd_addr     ut  upd_tgt      fl  pred_addr    eh  et  e_target
        add("reset",     0, 32'h0,        0, 32'h0,        0, 32'h100,     0, 0, 32'h0);
        add("alloc0",    1, 32'h100,      1, 32'h200,      0, 32'h000,     0, 0, 32'h0);
        add("hit100",    0, 32'h0,        0, 32'h0,        0, 32'h100,     1, 1, 32'h200);
        add("alias",     1, 32'h140,      1, 32'h240,      0, 32'h100,     1, 1, 32'h200);
        add("pre_evict", 1, 32'h180,      1, 32'h280,      0, 32'h140,     1, 1, 32'h240);
        add("hit180",    0, 32'h0,        0, 32'h0,        0, 32'h180,     1, 1, 32'h280);
        add("evicted",   0, 32'h0,        0, 32'h0,        0, 32'h100,     0, 0, 32'h0);
        add("kept140",   0, 32'h0,        0, 32'h0,        0, 32'h140,     1, 1, 32'h240);
        add("fwd_alloc", 1, 32'h1C0,      1, 32'h2C0,      0, 32'h1C0,     1, 1, 32'h2C0);
        add("vp_evict",  0, 32'h0,        0, 32'h0,        0, 32'h140,     0, 0, 32'h0);
        add("offset",    0, 32'h0,        0, 32'h0,        0, 32'h182,     1, 1, 32'h280);
        add("hi_tag",    0, 32'h0,        0, 32'h0,        0, 32'h80000180, 0, 0, 32'h0);
`ifdef BTB_HYSTERESIS_EN
        add("nt_fwd1",   1, 32'h180,      0, 32'h290,      0, 32'h180,     1, 0, 32'h290);
        add("ctr1",      0, 32'h0,        0, 32'h0,        0, 32'h180,     1, 0, 32'h290);
        add("nt2",       1, 32'h180,      0, 32'h290,      0, 32'h000,     0, 0, 32'h0);
        add("ctr0",      0, 32'h0,        0, 32'h0,        0, 32'h180,     1, 0, 32'h290);
        add("sat_lo",    1, 32'h180,      0, 32'h290,      0, 32'h180,     1, 0, 32'h290);
        add("up1",       1, 32'h180,      1, 32'h290,      0, 32'h180,     1, 0, 32'h290);
        add("up2",       1, 32'h180,      1, 32'h290,      0, 32'h180,     1, 1, 32'h290);
        add("up3",       1, 32'h180,      1, 32'h290,      0, 32'h180,     1, 1, 32'h290);
        add("sat_hi",    1, 32'h180,      1, 32'h290,      0, 32'h180,     1, 1, 32'h290);
        add("dn2",       1, 32'h180,      0, 32'h290,      0, 32'h180,     1, 1, 32'h290);
        add("dn1",       1, 32'h180,      0, 32'h290,      0, 32'h180,     1, 0, 32'h290);
`else
        add("retarget",  1, 32'h180,      1, 32'h288,      0, 32'h180,     1, 1, 32'h288);
        add("hit288",    0, 32'h0,        0, 32'h0,        0, 32'h180,     1, 1, 32'h288);
        add("nt_fwd",    1, 32'h180,      0, 32'h290,      0, 32'h180,     0, 0, 32'h0);
        add("nt_inval",  0, 32'h0,        0, 32'h0,        0, 32'h180,     0, 0, 32'h0);
        add("other_way", 0, 32'h0,        0, 32'h0,        0, 32'h1C0,     1, 1, 32'h2C0);
`endif
        add("miss_nt",   1, 32'h3C4,      0, 32'h5C4,      0, 32'h3C4,     0, 0, 32'h0);
        add("miss_nt2",  0, 32'h0,        0, 32'h0,        0, 32'h3C4,     0, 0, 32'h0);
        add("fwd300",    1, 32'h300,      1, 32'h400,      0, 32'h300,     1, 1, 32'h400);
        add("hit300",    1, 32'h104,      1, 32'h500,      0, 32'h300,     1, 1, 32'h400);
        add("flush",     1, 32'h100,      1, 32'h600,      1, 32'h104,     1, 1, 32'h500);
        add("fl_100",    0, 32'h0,        0, 32'h0,        0, 32'h100,     0, 0, 32'h0);
        add("fl_104",    0, 32'h0,        0, 32'h0,        0, 32'h104,     0, 0, 32'h0);
        add("fl_300",    0, 32'h0,        0, 32'h0,        0, 32'h300,     0, 0, 32'h0);
        add("fl_1C0",    1, 32'h100,      1, 32'h700,      0, 32'h1C0,     0, 0, 32'h0);
        add("post_fl",   0, 32'h0,        0, 32'h0,        0, 32'h100,     1, 1, 32'h700);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            upd_en     = vecs[i].upd_en;
            upd_addr   = vecs[i].upd_addr;
            upd_taken  = vecs[i].upd_taken;
            upd_target = vecs[i].upd_target;
            flush      = vecs[i].flush;
            pred_addr  = vecs[i].pred_addr;
            @(negedge clk);
            chk_out(vecs[i].name, vecs[i].e_hit, vecs[i].e_taken, vecs[i].e_target);
        end

        // Asynchronous reset in mid-cycle while an update is pending
        @(posedge clk);
        #1;
        upd_en = 1'b1; upd_addr = 32'h140; upd_taken = 1'b1; upd_target = 32'h900;
        flush = 1'b0; pred_addr = 32'h100;
        #1 chk_out("pre_rst", 1'b1, 1'b1, 32'h700);
        #1 rst_n = 1'b0;
        #1 chk_out("async_rst", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        upd_en = 1'b0;
        rst_n  = 1'b1;
        pred_addr = 32'h140;
        @(negedge clk);
        chk_out("rst_lost_upd", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1 pred_addr = 32'h100;
        @(negedge clk);
        chk_out("rst_cleared", 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
